l2_mem_ctrl: RTL and testbench

//  Memory controller between the L2 cache and Main_Memory.

---
 rtl/l2_mem_ctrl_if.sv | 25 ++
 rtl/l2_mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_l2_mem_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/l2_mem_ctrl_if.sv
// L2-side request/response bundle for the L2-to-main-memory controller.
// The master modport is the L2 cache. The slave modport is the controller.
`timescale 1ns/1ps
interface l2_mem_ctrl_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        wr_ready;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_last;
   logic        done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, wr_ready, rsp_valid, rsp_rdata, rsp_last, done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, wr_ready, rsp_valid, rsp_rdata, rsp_last, done
   );
endinterface

// File: rtl/l2_mem_ctrl.sv
// Closed-page DRAM controller for L2 line fills and writebacks.
// It sequences ACT, READ/WRITE and PRE, and moves one BURST_LEN x 64-bit line per request.
`timescale 1ns/1ps
module l2_mem_ctrl #(
   parameter int BURST_LEN = 4,
   parameter int ROW_W     = 12,
   parameter int COL_W     = 10,
   parameter int T_RCD     = 2,
   parameter int T_CAS     = 2,
   parameter int T_RP      = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   l2_mem_ctrl_if.slave     bus,
   output logic [ROW_W-1:0] mem_addr,
   output logic             mem_cs_n,
   output logic             mem_ras_n,
   output logic             mem_cas_n,
   output logic             mem_we_n,
   inout  wire  [63:0]      mem_dq
);

   localparam int MAX_T  = (T_RCD > T_CAS) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                           : ((T_CAS > T_RP) ? T_CAS : T_RP);
   localparam int WAIT_W = $clog2(MAX_T + 1);
   localparam int BEAT_W = $clog2(BURST_LEN) + 1;
   localparam logic [COL_W-1:0]  COL_MASK  = ~(COL_W'(BURST_LEN - 1));
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   localparam logic [3:0] CMD_IDLE  = 4'b1111;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;

   typedef enum logic [3:0] {
      S_IDLE, S_ACT, S_RCD, S_RD, S_WR, S_CL, S_RBURST, S_PRE, S_RP
   } state_t;

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic               we_q, we_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_last_q, rsp_last_d;
   logic [63:0]        rsp_rdata_q, rsp_rdata_d;
   logic [3:0]         cmd;
   logic               dq_oe;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^{bus.req_addr[2:0], bus.req_addr[31:ROW_W+COL_W+3]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         beat_q      <= '0;
         we_q        <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         beat_q      <= beat_d;
         we_q        <= we_d;
         row_q       <= row_d;
         col_q       <= col_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Commands and strobes decode straight from state, so an async reset clears them at once.
   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      beat_d        = beat_q;
      we_d          = we_q;
      row_d         = row_q;
      col_d         = col_q;
      rsp_valid_d   = 1'b0;
      rsp_last_d    = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      cmd           = CMD_NOP;
      mem_addr      = '0;
      dq_oe         = 1'b0;
      bus.req_ready = 1'b0;
      bus.wr_ready  = 1'b0;
      bus.done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            cmd           = CMD_IDLE;
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               row_d   = bus.req_addr[ROW_W+COL_W+2:COL_W+3];
               col_d   = bus.req_addr[COL_W+2:3] & COL_MASK;
               state_d = S_ACT;
            end
         end
         S_ACT: begin
            cmd      = CMD_ACT;
            mem_addr = row_q;
            beat_d   = '0;
            if (T_RCD > 1) begin
               wait_d  = WAIT_W'(T_RCD - 1);
               state_d = S_RCD;
            end else begin
               state_d = we_q ? S_WR : S_RD;
            end
         end
         S_RCD: begin
            if (wait_q == WAIT_W'(1)) state_d = we_q ? S_WR : S_RD;
            else                      wait_d  = wait_q - WAIT_W'(1);
         end
         S_RD: begin
            cmd      = CMD_READ;
            mem_addr = ROW_W'(col_q);
            if (T_CAS > 1) begin
               wait_d  = WAIT_W'(T_CAS - 1);
               state_d = S_CL;
            end else begin
               state_d = S_RBURST;
            end
         end
         S_CL: begin
            if (wait_q == WAIT_W'(1)) state_d = S_RBURST;
            else                      wait_d  = wait_q - WAIT_W'(1);
         end
         S_RBURST: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_dq;
            beat_d      = beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
               rsp_last_d = 1'b1;
               state_d    = S_PRE;
            end
         end
         S_WR: begin
            dq_oe        = 1'b1;
            bus.wr_ready = 1'b1;
            if (beat_q == '0) begin
               cmd      = CMD_WRITE;
               mem_addr = ROW_W'(col_q);
            end
            beat_d = beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) state_d = S_PRE;
         end
         S_PRE: begin
            cmd      = CMD_PRE;
            bus.done = we_q;
            if (T_RP > 1) begin
               wait_d  = WAIT_W'(T_RP - 1);
               state_d = S_RP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RP: begin
            if (wait_q == WAIT_W'(1)) state_d = S_IDLE;
            else                      wait_d  = wait_q - WAIT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n} = cmd;
   assign mem_dq        = dq_oe ? bus.req_wdata : 64'bz;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_last  = rsp_last_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Self-checking bench for l2_mem_ctrl. Each request's cycle-by-cycle behaviour is predicted from the
// timing rules (command cycles, beat windows, address split), and the bench acts as the DRAM data source.
`timescale 1ns/1ps
module tb_l2_mem_ctrl;

   localparam int BL    = 4;
   localparam int ROW_W = 12;
   localparam int COL_W = 10;
   localparam int T_RCD = 2;
   localparam int T_CAS = 2;
   localparam int T_RP  = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   l2_mem_ctrl_if bus();
   logic [ROW_W-1:0] mem_addr;
   logic             mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n;
   wire  [63:0]      mem_dq;
   logic [63:0]      tb_dq;
   logic             tb_dq_en;

   assign mem_dq = tb_dq_en ? tb_dq : 64'bz;

   l2_mem_ctrl #(
      .BURST_LEN(BL), .ROW_W(ROW_W), .COL_W(COL_W),
      .T_RCD(T_RCD), .T_CAS(T_CAS), .T_RP(T_RP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .mem_addr(mem_addr), .mem_cs_n(mem_cs_n), .mem_ras_n(mem_ras_n),
      .mem_cas_n(mem_cas_n), .mem_we_n(mem_we_n), .mem_dq(mem_dq)
   );

   int          checks = 0;
   int          errors = 0;
   bit          directed;
   bit          pend_valid;
   bit          pend_we;
   logic [31:0] pend_addr;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic valid);
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_valid = valid;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_cmd"},       {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n}, 64'hF);
      checkOutput({tag, "_dq"},        mem_dq, 64'bz);
      checkOutput({tag, "_req_ready"}, bus.req_ready, 1);
      checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
   endtask

   // Runs one request from accept to the cycle where req_ready returns; enters and leaves on a negedge.
   task automatic runTxn(input bit we, input logic [31:0] addr, input int abortAt);
      int               cmdC, firstRsp, lastRsp, preC, doneC, waitCnt;
      logic [ROW_W-1:0] expRow, expCol;
      logic [63:0]      rdata[BL];
      logic [63:0]      wdata[BL];
      logic [3:0]       expCmd;
      logic [63:0]      expDq;
      bit               inBeat, inRsp;

      expRow   = ROW_W'((addr >> (COL_W + 3)) % (1 << ROW_W));
      expCol   = ROW_W'(((addr >> 3) % (1 << COL_W)) / BL * BL);
      cmdC     = 1 + T_RCD;
      firstRsp = cmdC + T_CAS + 1;
      lastRsp  = firstRsp + BL - 1;
      preC     = we ? cmdC + BL : lastRsp;
      doneC    = preC + T_RP;
      for (int i = 0; i < BL; i++) begin
         rdata[i] = directed ? 64'(8'hA0 + i)        : {$urandom, $urandom};
         wdata[i] = directed ? 64'(8'h11 * (i + 1))  : {$urandom, $urandom};
      end

      applyStimulus(we, addr, 1'b1);
      waitCnt = 0;
      while (!bus.req_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (waitCnt >= 50) begin
         checkOutput("accept_timeout", 0, 1);
         applyStimulus(1'b0, 32'h0, 1'b0);
         return;
      end
      @(posedge clk);
      #1;
      applyStimulus(1'($urandom), $urandom, 1'b0);

      for (int c = 1; c <= doneC; c++) begin
         if (pend_valid && c == 2) applyStimulus(pend_we, pend_addr, 1'b1);
         tb_dq_en = !we && c >= cmdC + T_CAS && c < cmdC + T_CAS + BL;
         tb_dq    = tb_dq_en ? rdata[c - cmdC - T_CAS] : 64'h0;
         inBeat   = we && c >= cmdC && c < cmdC + BL;
         bus.req_wdata = inBeat ? wdata[c - cmdC] : {$urandom, $urandom};

         if (c == abortAt) begin
            tb_dq_en = 1'b0;
            #2 rst_n = 1'b0;
            #1 checkIdleOutputs($sformatf("abort_c%0d", c));
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               checkIdleOutputs($sformatf("abort_hold%0d", k));
            end
            rst_n = 1'b1;
            return;
         end

         @(negedge clk);
         if      (c == 1)     expCmd = 4'b0011;
         else if (c == cmdC)  expCmd = we ? 4'b0100 : 4'b0101;
         else if (c == preC)  expCmd = 4'b0010;
         else if (c == doneC) expCmd = 4'b1111;
         else                 expCmd = 4'b0111;
         inRsp = !we && c >= firstRsp && c <= lastRsp;
         expDq = inBeat ? wdata[c - cmdC] : (tb_dq_en ? tb_dq : 64'bz);

         checkOutput($sformatf("c%0d_cmd", c), {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n}, expCmd);
         if (c == 1)    checkOutput("act_row", mem_addr, expRow);
         if (c == cmdC) checkOutput("cmd_col", mem_addr, expCol);
         checkOutput($sformatf("c%0d_req_ready", c), bus.req_ready, c == doneC);
         checkOutput($sformatf("c%0d_rsp_valid", c), bus.rsp_valid, inRsp);
         checkOutput($sformatf("c%0d_rsp_last", c),  bus.rsp_last, !we && c == lastRsp);
         if (inRsp) checkOutput($sformatf("c%0d_rsp_rdata", c), bus.rsp_rdata, rdata[c - firstRsp]);
         checkOutput($sformatf("c%0d_wr_ready", c), bus.wr_ready, inBeat);
         checkOutput($sformatf("c%0d_done", c), bus.done, we && c == preC);
         checkOutput($sformatf("c%0d_dq", c), mem_dq, expDq);
         if (c < doneC) begin
            @(posedge clk);
            #1;
         end
      end
      tb_dq_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      tb_dq_en      = 1'b0;
      tb_dq         = 64'h0;
      bus.req_wdata = 64'h0;
      directed      = 1'b1;
      pend_valid    = 1'b0;
      pend_we       = 1'b0;
      pend_addr     = 32'h0;
      applyStimulus(1'b0, 32'h0, 1'b0);

      repeat (2) @(negedge clk);
      checkIdleOutputs("reset");
      checkOutput("reset_rsp_rdata", bus.rsp_rdata, 0);
      checkOutput("reset_rsp_last", bus.rsp_last, 0);
      checkOutput("reset_wr_ready", bus.wr_ready, 0);
      checkOutput("reset_done", bus.done, 0);
      checkOutput("reset_mem_addr", mem_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed read 0x00012340");
      runTxn(1'b0, 32'h0001_2340, 0);
      $display("[TB] directed write 0x00000020");
      runTxn(1'b1, 32'h0000_0020, 0);
      $display("[TB] column alignment read 0x00000038");
      runTxn(1'b0, 32'h0000_0038, 0);

      $display("[TB] back-to-back read then held write");
      directed   = 1'b0;
      pend_valid = 1'b1;
      pend_we    = 1'b1;
      pend_addr  = 32'h0ABC_DE40;
      runTxn(1'b0, 32'h1234_5678, 0);
      pend_valid = 1'b0;
      runTxn(pend_we, pend_addr, 0);

      $display("[TB] reset during write, then during read at C5");
      runTxn(1'b1, $urandom, 4);
      @(negedge clk);
      runTxn(1'b0, $urandom, 5);
      @(negedge clk);
      directed = 1'b1;
      runTxn(1'b0, 32'h0001_2340, 0);

      $display("[TB] randomized requests");
      directed = 1'b0;
      for (int n = 0; n < 20; n++) begin
         pend_valid = ($urandom_range(0, 3) == 0);
         pend_we    = 1'($urandom);
         pend_addr  = $urandom;
         runTxn(1'($urandom), $urandom, 0);
         if (pend_valid) begin
            pend_valid = 1'b0;
            runTxn(pend_we, pend_addr, 0);
         end
      end

      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
